// File: rtl/multi_alarm_timekeeper.sv
// rtl/multi_alarm_timekeeper.sv - 24h timekeeper with armed alarm bank, ring timeout and snooze (TIMEKEEPER_SNOOZE_EN)
module multi_alarm_timekeeper #(
    parameter int TICKS_PER_SEC = 1,
    parameter int NUM_ALARMS    = 4,
    parameter int RING_SEC      = 60,
    parameter int SNOOZE_MIN    = 5,
    parameter int AW            = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  add_hour,
    input  logic                  add_minute,
    input  logic                  am_mode,
    input  logic                  alarm_wr,
    input  logic                  alarm_clr,
    input  logic [AW-1:0]         alarm_sel,
    input  logic [4:0]            alarm_hr_in,
    input  logic [5:0]            alarm_min_in,
    input  logic                  snooze,
    input  logic                  dismiss,
    output logic [5:0]            sec,
    output logic [5:0]            min,
    output logic [4:0]            hr,
    output logic                  am_pm,
    output logic                  tick,
    output logic [NUM_ALARMS-1:0] alarm_armed,
    output logic [NUM_ALARMS-1:0] alarm_ringing,
    output logic                  buzzer
);

    localparam int PW  = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int RCW = $clog2(RING_SEC + 1);

`ifdef TIMEKEEPER_SNOOZE_EN
    localparam int SCW = $clog2(SNOOZE_MIN * 60 + 1);
    typedef enum logic [1:0] {S_IDLE, S_RINGING, S_SNOOZED} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_RINGING} state_t;
`endif

    logic [PW-1:0] r_presc;
    logic [5:0]    r_sec;
    logic [5:0]    r_min;
    logic [4:0]    r_hr;
    logic          r_tick;
    logic          r_hour_prev;
    logic          r_min_prev;

    logic          w_hour_edge;
    logic          w_min_edge;
    logic          w_adj;
    logic          w_term;
    logic          w_sel_valid;
    logic          w_wr_ok;
    logic          w_clr_ok;
    logic [4:0]    w_hr_mod;

    state_t        r_state    [NUM_ALARMS];
    state_t        w_state_nx [NUM_ALARMS];
    logic          r_armed    [NUM_ALARMS];
    logic          w_armed_nx [NUM_ALARMS];
    logic [4:0]    r_al_hr    [NUM_ALARMS];
    logic [4:0]    w_al_hr_nx [NUM_ALARMS];
    logic [5:0]    r_al_min   [NUM_ALARMS];
    logic [5:0]    w_al_min_nx[NUM_ALARMS];
    logic [RCW-1:0] r_ring_cnt   [NUM_ALARMS];
    logic [RCW-1:0] w_ring_cnt_nx[NUM_ALARMS];
`ifdef TIMEKEEPER_SNOOZE_EN
    logic [SCW-1:0] r_snz_cnt    [NUM_ALARMS];
    logic [SCW-1:0] w_snz_cnt_nx [NUM_ALARMS];
`else
    logic           w_unused_snooze;
    assign w_unused_snooze = snooze;
`endif

    assign w_hour_edge = add_hour & ~r_hour_prev;
    assign w_min_edge  = add_minute & ~r_min_prev;
    assign w_adj       = w_hour_edge | w_min_edge;
    assign w_term      = (r_presc == PW'(TICKS_PER_SEC - 1));
    assign w_sel_valid = (int'(alarm_sel) < NUM_ALARMS);
    assign w_wr_ok     = alarm_wr & w_sel_valid & (alarm_hr_in <= 5'd23) & (alarm_min_in <= 6'd59);
    assign w_clr_ok    = alarm_clr & w_sel_valid;

    // Prescaler, time-of-day counters and adjust-button edge detection; an adjust edge freezes the prescaler
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_presc     <= '0;
            r_sec       <= '0;
            r_min       <= '0;
            r_hr        <= '0;
            r_tick      <= 1'b0;
            r_hour_prev <= 1'b0;
            r_min_prev  <= 1'b0;
        end else begin
            r_hour_prev <= add_hour;
            r_min_prev  <= add_minute;
            r_tick      <= 1'b0;
            if (w_adj) begin
                if (w_min_edge) begin
                    r_min <= (r_min == 6'd59) ? 6'd0 : r_min + 6'd1;
                end
                if (w_hour_edge) begin
                    r_hr <= (r_hr == 5'd23) ? 5'd0 : r_hr + 5'd1;
                end
            end else if (w_term) begin
                r_presc <= '0;
                r_tick  <= 1'b1;
                if (r_sec == 6'd59) begin
                    r_sec <= 6'd0;
                    if (r_min == 6'd59) begin
                        r_min <= 6'd0;
                        r_hr  <= (r_hr == 5'd23) ? 5'd0 : r_hr + 5'd1;
                    end else begin
                        r_min <= r_min + 6'd1;
                    end
                end else begin
                    r_sec <= r_sec + 6'd1;
                end
            end else begin
                r_presc <= r_presc + PW'(1);
            end
        end
    end

    // Alarm bank state registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_ALARMS; i++) begin
                r_state[i]    <= S_IDLE;
                r_armed[i]    <= 1'b0;
                r_al_hr[i]    <= '0;
                r_al_min[i]   <= '0;
                r_ring_cnt[i] <= '0;
`ifdef TIMEKEEPER_SNOOZE_EN
                r_snz_cnt[i]  <= '0;
`endif
            end
        end else begin
            for (int i = 0; i < NUM_ALARMS; i++) begin
                r_state[i]    <= w_state_nx[i];
                r_armed[i]    <= w_armed_nx[i];
                r_al_hr[i]    <= w_al_hr_nx[i];
                r_al_min[i]   <= w_al_min_nx[i];
                r_ring_cnt[i] <= w_ring_cnt_nx[i];
`ifdef TIMEKEEPER_SNOOZE_EN
                r_snz_cnt[i]  <= w_snz_cnt_nx[i];
`endif
            end
        end
    end

    // Per-alarm next state: clear/write beat dismiss, dismiss beats snooze, snooze beats timeout/match
    always_comb begin
        for (int i = 0; i < NUM_ALARMS; i++) begin
            w_state_nx[i]    = r_state[i];
            w_armed_nx[i]    = r_armed[i];
            w_al_hr_nx[i]    = r_al_hr[i];
            w_al_min_nx[i]   = r_al_min[i];
            w_ring_cnt_nx[i] = r_ring_cnt[i];
`ifdef TIMEKEEPER_SNOOZE_EN
            w_snz_cnt_nx[i]  = r_snz_cnt[i];
`endif
            if (w_clr_ok && (alarm_sel == AW'(i))) begin
                w_armed_nx[i] = 1'b0;
                w_state_nx[i] = S_IDLE;
            end else if (w_wr_ok && (alarm_sel == AW'(i))) begin
                w_armed_nx[i]  = 1'b1;
                w_al_hr_nx[i]  = alarm_hr_in;
                w_al_min_nx[i] = alarm_min_in;
                w_state_nx[i]  = S_IDLE;
            end else begin
                case (r_state[i])
                    S_IDLE: begin
                        if (r_armed[i] && r_tick && (r_hr == r_al_hr[i]) &&
                            (r_min == r_al_min[i]) && (r_sec == 6'd0)) begin
                            w_state_nx[i]    = S_RINGING;
                            w_ring_cnt_nx[i] = RCW'(RING_SEC);
                        end
                    end
                    S_RINGING: begin
                        if (dismiss) begin
                            w_state_nx[i] = S_IDLE;
`ifdef TIMEKEEPER_SNOOZE_EN
                        end else if (snooze) begin
                            w_state_nx[i]   = S_SNOOZED;
                            w_snz_cnt_nx[i] = SCW'(SNOOZE_MIN * 60);
`endif
                        end else if (r_tick) begin
                            if (r_ring_cnt[i] <= RCW'(1)) begin
                                w_state_nx[i] = S_IDLE;
                            end else begin
                                w_ring_cnt_nx[i] = r_ring_cnt[i] - RCW'(1);
                            end
                        end
                    end
`ifdef TIMEKEEPER_SNOOZE_EN
                    S_SNOOZED: begin
                        if (dismiss) begin
                            w_state_nx[i] = S_IDLE;
                        end else if (r_tick) begin
                            if (r_snz_cnt[i] <= SCW'(1)) begin
                                w_state_nx[i]    = S_RINGING;
                                w_ring_cnt_nx[i] = RCW'(RING_SEC);
                            end else begin
                                w_snz_cnt_nx[i] = r_snz_cnt[i] - SCW'(1);
                            end
                        end
                    end
`endif
                    default: w_state_nx[i] = S_IDLE;
                endcase
            end
        end
    end

    // Status vectors, shared buzzer and 12/24-hour display mapping
    always_comb begin
        alarm_armed   = '0;
        alarm_ringing = '0;
        for (int i = 0; i < NUM_ALARMS; i++) begin
            alarm_armed[i]   = r_armed[i];
            alarm_ringing[i] = (r_state[i] == S_RINGING);
        end
        buzzer   = |alarm_ringing;
        w_hr_mod = (r_hr >= 5'd12) ? (r_hr - 5'd12) : r_hr;
        if (am_mode) begin
            hr    = (w_hr_mod == 5'd0) ? 5'd12 : w_hr_mod;
            am_pm = (r_hr >= 5'd12);
        end else begin
            hr    = r_hr;
            am_pm = 1'b0;
        end
        sec  = r_sec;
        min  = r_min;
        tick = r_tick;
    end

endmodule

// File: tb/tb_multi_alarm_timekeeper.sv
// tb/tb_multi_alarm_timekeeper.sv - directed scoreboard bench for multi_alarm_timekeeper
module tb_multi_alarm_timekeeper;

    localparam int TPS = 2;
    localparam int NA  = 3;
    localparam int RS  = 60;
    localparam int SM  = 5;
    localparam int AWT = 2;

    logic           clk = 1'b0;
    logic           reset_n;
    logic           add_hour, add_minute, am_mode;
    logic           alarm_wr, alarm_clr;
    logic [AWT-1:0] alarm_sel;
    logic [4:0]     alarm_hr_in;
    logic [5:0]     alarm_min_in;
    logic           snooze, dismiss;
    logic [5:0]     sec, min;
    logic [4:0]     hr;
    logic           am_pm, tick, buzzer;
    logic [NA-1:0]  alarm_armed, alarm_ringing;

    multi_alarm_timekeeper #(
        .TICKS_PER_SEC(TPS), .NUM_ALARMS(NA), .RING_SEC(RS), .SNOOZE_MIN(SM), .AW(AWT)
    ) dut (
        .clk(clk), .reset_n(reset_n), .add_hour(add_hour), .add_minute(add_minute),
        .am_mode(am_mode), .alarm_wr(alarm_wr), .alarm_clr(alarm_clr), .alarm_sel(alarm_sel),
        .alarm_hr_in(alarm_hr_in), .alarm_min_in(alarm_min_in), .snooze(snooze), .dismiss(dismiss),
        .sec(sec), .min(min), .hr(hr), .am_pm(am_pm), .tick(tick),
        .alarm_armed(alarm_armed), .alarm_ringing(alarm_ringing), .buzzer(buzzer)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_t;

    sb_t sb_q[$];
    int  checks   = 0;
    int  failures = 0;

    task automatic expect_val(input string tag, input logic [31:0] exp);
        sb_t e;
        e.tag = tag;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic compare(input logic [31:0] obs);
        sb_t e;
        checks++;
        if (sb_q.size() == 0) begin
            failures++;
            $error("FAIL scoreboard_empty observed=%0h expected=none", obs);
        end else begin
            e = sb_q.pop_front();
            assert (obs === e.exp) else begin
                failures++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_hms(input int h, input int m, input int s, input int budget, input string tag);
        int n = 0;
        while (!(int'(hr) == h && int'(min) == m && int'(sec) == s) && n < budget) begin
            step(1);
            n++;
        end
        expect_val(tag, 1);
        compare((int'(hr) == h && int'(min) == m && int'(sec) == s) ? 1 : 0);
    endtask

    task automatic write_alarm(input int sel, input int h, input int m);
        alarm_sel    = AWT'(sel);
        alarm_hr_in  = 5'(h);
        alarm_min_in = 6'(m);
        alarm_wr     = 1'b1;
        step(1);
        alarm_wr     = 1'b0;
    endtask

    task automatic clear_alarm(input int sel);
        alarm_sel = AWT'(sel);
        alarm_clr = 1'b1;
        step(1);
        alarm_clr = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int tcount;
        int bad;
        int n;
        int tgt;
        int tgt2;
        int tgt3;
        logic [5:0] prev;

        reset_n = 1'b0; add_hour = 1'b0; add_minute = 1'b0; am_mode = 1'b1;
        alarm_wr = 1'b0; alarm_clr = 1'b0; alarm_sel = '0; alarm_hr_in = '0;
        alarm_min_in = '0; snooze = 1'b0; dismiss = 1'b0;
        #12;
        expect_val("rst_sec", 0);      compare(sec);
        expect_val("rst_min", 0);      compare(min);
        expect_val("rst_hr12", 12);    compare(hr);
        expect_val("rst_ampm", 0);     compare(am_pm);
        expect_val("rst_tick", 0);     compare(tick);
        expect_val("rst_armed", 0);    compare(alarm_armed);
        expect_val("rst_ringing", 0);  compare(alarm_ringing);
        expect_val("rst_buzzer", 0);   compare(buzzer);
        am_mode = 1'b0; #1;
        expect_val("rst_hr24", 0);     compare(hr);
        @(posedge clk); #1;
        reset_n = 1'b1;
        step(1);

        // manual set: 22 simultaneous hour+minute edges
        for (int k = 0; k < 22; k++) begin
            add_hour = 1'b1; add_minute = 1'b1; step(1);
            add_hour = 1'b0; add_minute = 1'b0; step(1);
        end
        am_mode = 1'b1; #1;
        expect_val("set_hr12", 10);    compare(hr);
        expect_val("set_ampm", 1);     compare(am_pm);
        expect_val("set_min", 22);     compare(min);
        am_mode = 1'b0; #1;
        expect_val("set_hr24", 22);    compare(hr);
        expect_val("set_ampm24", 0);   compare(am_pm);

        // rollover: set 23:58, wait for 23:59:00, then 60 ticks to midnight
        reset_n = 1'b0; #2; reset_n = 1'b1;
        step(1);
        for (int k = 0; k < 23; k++) begin
            add_hour = 1'b1; add_minute = 1'b1; step(1);
            add_hour = 1'b0; add_minute = 1'b0; step(1);
        end
        for (int k = 0; k < 35; k++) begin
            add_minute = 1'b1; step(1);
            add_minute = 1'b0; step(1);
        end
        expect_val("roll_set_hr", 23); compare(hr);
        expect_val("roll_set_min", 58); compare(min);
        wait_hms(23, 59, 0, 300, "roll_reach_2359");
        tcount = 0; bad = 0; n = 0; prev = sec;
        while (!(hr == 5'd0 && min == 6'd0 && sec == 6'd0) && n < 400) begin
            step(1);
            n++;
            if (tick) tcount++;
            if ((sec != prev) != tick) bad++;
            prev = sec;
        end
        expect_val("roll_midnight", 1);
        compare((hr == 5'd0 && min == 6'd0 && sec == 6'd0) ? 1 : 0);
        expect_val("roll_tick_count", 60); compare(tcount);
        expect_val("roll_tick_align", 0);  compare(bad);
        am_mode = 1'b1; #1;
        expect_val("roll_hr12", 12);   compare(hr);
        expect_val("roll_ampm", 0);    compare(am_pm);
        am_mode = 1'b0; #1;

        // alarm 2 at 00:01 fires one cycle after match, times out after 60 ticks
        write_alarm(2, 0, 1);
        expect_val("a2_armed", 3'b100);   compare(alarm_armed);
        expect_val("a2_idle", 3'b000);    compare(alarm_ringing);
        wait_hms(0, 1, 0, 300, "a2_reach_0001");
        expect_val("a2_not_yet", 3'b000); compare(alarm_ringing);
        step(1);
        expect_val("a2_ring", 3'b100);    compare(alarm_ringing);
        expect_val("a2_buzzer", 1);       compare(buzzer);
        wait_hms(0, 2, 0, 300, "a2_reach_0002");
        expect_val("a2_last_ring", 3'b100); compare(alarm_ringing);
        step(1);
        expect_val("a2_timeout", 3'b000); compare(alarm_ringing);
        expect_val("a2_buz_off", 0);      compare(buzzer);
        expect_val("a2_still_armed", 3'b100); compare(alarm_armed);

        // snooze on alarm 0 at 00:03
        write_alarm(0, 0, 3);
        expect_val("a0_armed", 3'b101);   compare(alarm_armed);
        wait_hms(0, 3, 0, 300, "a0_reach_0003");
        step(1);
        expect_val("a0_ring", 3'b001);    compare(alarm_ringing);
        snooze = 1'b1; step(1); snooze = 1'b0;
`ifdef TIMEKEEPER_SNOOZE_EN
        expect_val("snz_buz_off", 0);     compare(buzzer);
        tcount = 0; n = 0;
        while (!alarm_ringing[0] && n < 800) begin
            if (tick) tcount++;
            step(1);
            n++;
        end
        expect_val("snz_rering", 3'b001); compare(alarm_ringing);
        expect_val("snz_ticks", SM * 60); compare(tcount);
`else
        expect_val("snz_ignored", 3'b001); compare(alarm_ringing);
        expect_val("snz_ign_buz", 1);      compare(buzzer);
`endif
        snooze = 1'b1; dismiss = 1'b1; step(1); snooze = 1'b0; dismiss = 1'b0;
        expect_val("snzdis_buz", 0);       compare(buzzer);
        step(4);
        expect_val("snzdis_idle", 3'b000); compare(alarm_ringing);

        // two alarms at the same time
        tgt = (int'(min) + 2) % 60;
        write_alarm(0, 0, tgt);
        write_alarm(1, 0, tgt);
        expect_val("dual_armed", 3'b111);  compare(alarm_armed);
        wait_hms(0, tgt, 0, 500, "dual_reach");
        step(1);
        expect_val("dual_ring", 3'b011);   compare(alarm_ringing);
        expect_val("dual_buzzer", 1);      compare(buzzer);

        // invalid writes leave everything untouched
        write_alarm(3, 0, 0);
        expect_val("inv_sel_armed", 3'b111); compare(alarm_armed);
        expect_val("inv_sel_ring", 3'b011);  compare(alarm_ringing);
        write_alarm(0, 24, 0);
        expect_val("inv_hr_ring", 3'b011);   compare(alarm_ringing);
        write_alarm(0, 0, 60);
        expect_val("inv_min_ring", 3'b011);  compare(alarm_ringing);

        // overriding write to a ringing alarm
        tgt2 = (tgt + 2) % 60;
        write_alarm(1, 0, tgt2);
        expect_val("ovr_ring", 3'b001);      compare(alarm_ringing);
        expect_val("ovr_armed", 3'b111);     compare(alarm_armed);
        wait_hms(0, tgt2, 0, 500, "ovr_reach");
        expect_val("ovr_pre", 3'b000);       compare(alarm_ringing);
        step(1);
        expect_val("ovr_fire", 3'b010);      compare(alarm_ringing);

        // clear a ringing alarm and an idle one
        clear_alarm(1);
        expect_val("clr1_ring", 3'b000);     compare(alarm_ringing);
        expect_val("clr1_armed", 3'b101);    compare(alarm_armed);
        clear_alarm(2);
        expect_val("clr2_armed", 3'b001);    compare(alarm_armed);

        // asynchronous reset while ringing
        tgt3 = (tgt2 + 1) % 60;
        write_alarm(1, 0, tgt3);
        wait_hms(0, tgt3, 0, 500, "arst_reach");
        step(1);
        expect_val("arst_ring", 3'b010);     compare(alarm_ringing);
        #3 reset_n = 1'b0;
        #1;
        expect_val("arst_buzzer", 0);        compare(buzzer);
        expect_val("arst_ringing", 3'b000);  compare(alarm_ringing);
        expect_val("arst_armed", 3'b000);    compare(alarm_armed);
        expect_val("arst_min", 0);           compare(min);
        step(1);
        reset_n = 1'b1;
        step(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
